// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
// The master issues req/we/addr/be/wdata; the memory answers with rdata qualified by ack.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM access requests into one req/ack bus transaction,
// stalls the pipeline while it is in flight, and returns lane-selected, extended load data.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Memread_in,
  input  logic                 Memwrite_in,
  input  logic                 Byte_in,
  input  logic                 Signext2_in,
  input  logic [31:0]          ALU_result_in,
  input  logic [31:0]          B_in,
  mem_access_unit_if.master    dmem,
  output logic                 stall,
  output logic [31:0]          Mem_data_out,
  output logic                 Mem_valid_out,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Abort fires on the BUSY cycle whose counter value is MAX_WAIT-1, i.e. after MAX_WAIT cycles.
  localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_byte;
  logic        r_sext;
  logic [1:0]  r_lane;
  logic [7:0]  r_wait;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_timeout;

  logic        w_access;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_rbyte;
  logic [31:0] w_load_fmt;

  assign w_access = Memread_in | Memwrite_in;
  assign w_lane   = ALU_result_in[1:0];
  assign w_be     = Byte_in ? (4'b0001 << w_lane) : 4'hF;
  assign w_wdata  = Byte_in ? {4{B_in[7:0]}} : B_in;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_rbyte unassigned (no latch).
    w_rbyte = 8'h00;
    case (r_lane)
      2'd0: w_rbyte = dmem.dmem_rdata[7:0];
      2'd1: w_rbyte = dmem.dmem_rdata[15:8];
      2'd2: w_rbyte = dmem.dmem_rdata[23:16];
      2'd3: w_rbyte = dmem.dmem_rdata[31:24];
      default: w_rbyte = 8'h00;
    endcase
  end

  assign w_load_fmt = !r_byte ? dmem.dmem_rdata
                    : r_sext  ? {{24{w_rbyte[7]}}, w_rbyte}
                    :           {24'h000000, w_rbyte};

  // Stall must rise in the detect cycle itself, so it is the one combinational output.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_access;
      S_BUSY:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_byte    <= 1'b0;
      r_sext    <= 1'b0;
      r_lane    <= '0;
      r_wait    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (w_access) begin
            r_state <= S_BUSY;
            r_req   <= 1'b1;
            r_we    <= Memwrite_in;
            r_addr  <= {ALU_result_in[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_byte  <= Byte_in;
            r_sext  <= Signext2_in;
            r_lane  <= w_lane;
            r_wait  <= '0;
          end
        end

        S_BUSY: begin
          r_wait <= r_wait + 8'd1;
          if (dmem.dmem_ack) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_data  <= r_we ? 32'h0 : w_load_fmt;
          end else if (r_wait == LP_WAIT_LAST) begin
            r_state   <= S_DONE;
            r_req     <= 1'b0;
            r_valid   <= 1'b1;
            r_data    <= 32'h0;
            r_timeout <= 1'b1;
          end
        end

        // EX/MEM still shows the finished instruction here, so requests are ignored.
        S_DONE: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;
  assign Mem_data_out    = r_data;
  assign Mem_valid_out   = r_valid;
  assign timeout_err     = r_timeout;

endmodule
